serial_link: RTL and testbench
==============================

// Module: serial_link
// PURPOSE
//  Game Boy serial port peripheral (SB/SC MMIO). Sits beside timers on the CPU's
//  addr_ext/data_ext bus and feeds IF_in[I_SERIAL]/IF_load. Shifts one byte MSB-first
//  per transfer on an internal or external serial clock and pulses an interrupt when done.
// PARAMETERS
//  CLK_DIV  512       system clocks per serial bit; even, >=4 (4.19MHz/512 = 8192Hz)
//  SB_ADDR  16'hFF01  MMIO address of the data/shift register
//  SC_ADDR  16'hFF02  MMIO address of the control register
// PORTS
//  clock            in     1   system clock, all state on posedge
//  reset            in     1   asynchronous, active-low reset
//  addr_ext         in     16  CPU/DMA address bus
//  data_ext         inout  8   shared data bus; driven only on register reads
//  mem_re           in     1   active-high read strobe
//  mem_we           in     1   active-high write strobe
//  sclk_in          in     1   external serial clock, asynchronous
//  serial_in        in     1   serial data in, sampled on sclk rising edge
//  sclk_out         out    1   internal serial clock, idle high
//  serial_out       out    1   serial data out, changes on sclk falling edge
//  serial_interrupt out    1   one-cycle completion pulse to IF_in[I_SERIAL]/IF_load
// BEHAVIOUR
//  Reset (reset==0, async): SB=8'h00, SC.start=0, SC.clksel=0, FSM=IDLE, sclk_out=1,
//   serial_out=1, serial_interrupt=0, sync flops=1, data_ext=Z.
//  Reads: combinational. mem_re & addr==SB_ADDR -> data_ext=SB; addr==SC_ADDR ->
//   {start,6'b111111,clksel}; otherwise data_ext=8'hZZ.
//  Writes: sampled at posedge when mem_we & address match. SC write loads start=d[7],
//   clksel=d[0]. SB write is ignored outside IDLE.
//  FSM IDLE -> SHIFT when SC written with d[7]=1. SHIFT -> IDLE after the 8th sclk rising
//   edge (interrupt) or SC written with d[7]=0 (abort: no interrupt, SB keeps partial
//   shift, sclk_out->1).
//  Internal clock (clksel=1), H=CLK_DIV/2, start-write edge T:
//   - T+1: sclk_out=0, serial_out=SB[7]; divider counts H cycles per half-period.
//   - Rising edge (sclk_out 0->1): SB <= {SB[6:0],serial_in}; bit count +1.
//   - Falling edge: serial_out <= SB[7] (next bit).
//   - 8th rising edge at T+1+15H; on the next edge: SC.start=0, serial_interrupt=1 for
//     exactly one cycle, sclk_out stays 1, serial_out holds last bit.
//  External clock (clksel=0): sclk_in through 2-flop synchronizer (2-cycle latency);
//   synchronized rising edge shifts in, falling edge updates serial_out; same 8-edge
//   completion rule. sclk_out held 1. No timeout: waits indefinitely.
//  serial_out=SB[7] on entry to SHIFT in both modes.
//  Widths: 3-bit bit counter wraps 7->0 on completion; divider $clog2(CLK_DIV/2) bits,
//   reset to 0 on every SHIFT entry.
//  Simultaneous events:
//   - SC start write on the completion edge: interrupt still pulses; new transfer
//     starts (FSM re-enters SHIFT).
//   - SC write with d[7]=1 during SHIFT: clksel updated, transfer continues, counter
//     not reset.
//   - Read of SB during SHIFT returns the partial shift value.
//  Reset mid-transfer: immediate return to reset values; no interrupt.
// TESTING (CLK_DIV=4 unless stated)
//  1. Reset low with bus idle -> data_ext=Z, sclk_out=1, serial_out=1, interrupt=0;
//     read SC -> 8'h7E.
//  2. SB<=8'hA5, SC<=8'h81, serial_in tied to serial_out -> serial_out bit sequence
//     1,0,1,0,0,1,0,1; interrupt high exactly at T+32 for one cycle; SB reads 8'hA5;
//     SC reads 8'h7F.
//  3. SB<=8'h3C, SC<=8'h81, serial_in=1 -> SB=8'hFF after completion; read at bit 4 gives
//     8'hCF (partial shift).
//  4. SC<=8'h80, drive 8 sclk_in pulses (10-cycle period), serial_in=0, SB=8'hFF ->
//     SB=8'h00, one interrupt pulse 2-3 cycles after the 8th rising edge; sclk_out stays 1.
//  5. Start internal transfer, SC<=8'h01 after 3 bits -> no interrupt, FSM IDLE,
//     sclk_out=1; SB write during SHIFT is ignored; SB write after abort takes effect.
//  6. reset asserted mid-transfer at bit 5 -> all outputs at reset values immediately;
//     after release, no interrupt pulse.

Source files
------------

// File: rtl/serial_link.sv
// Game Boy serial port: SB/SC registers, MSB-first byte shifter with
// internal divided clock or synchronized external clock, and done interrupt.
module serial_link #(
    parameter int          CLK_DIV = 512,
    parameter logic [15:0] SB_ADDR = 16'hFF01,
    parameter logic [15:0] SC_ADDR = 16'hFF02
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] addr_ext,
    inout  wire  [7:0]  data_ext,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic        sclk_in,
    input  logic        serial_in,
    output logic        sclk_out,
    output logic        serial_out,
    output logic        serial_interrupt
);

    localparam int H  = CLK_DIV / 2;
    localparam int DW = $clog2(H);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state, state_n;
    logic [7:0]      sb, sb_n;
    logic            start, start_n;
    logic            clksel, clksel_n;
    logic [2:0]      bit_cnt, bit_cnt_n;
    logic [DW-1:0]   div, div_n;
    logic            first, first_n;
    logic            sclk_n, sout_n, irq_n;
    logic [1:0]      sync, sync_n;

    logic            sb_hit, sc_hit, sb_wr, sc_wr, go, stop;
    logic            rise, fall, ext_rise, ext_fall;
    logic [7:0]      rd_val;

    assign sb_hit = (addr_ext == SB_ADDR);
    assign sc_hit = (addr_ext == SC_ADDR);
    assign sb_wr  = mem_we && sb_hit;
    assign sc_wr  = mem_we && sc_hit;
    assign go     = sc_wr && data_ext[7];
    assign stop   = sc_wr && !data_ext[7];

    assign rd_val   = sb_hit ? sb : {start, 6'b111111, clksel};
    assign data_ext = (mem_re && (sb_hit || sc_hit)) ? rd_val : 8'hzz;

    // edge detect across the two synchronizer stages
    assign ext_rise = sync[0] && !sync[1];
    assign ext_fall = !sync[0] && sync[1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            sb               <= 8'h00;
            start            <= 1'b0;
            clksel           <= 1'b0;
            bit_cnt          <= 3'd0;
            div              <= '0;
            first            <= 1'b0;
            sclk_out         <= 1'b1;
            serial_out       <= 1'b1;
            serial_interrupt <= 1'b0;
            sync             <= 2'b11;
        end else begin
            state            <= state_n;
            sb               <= sb_n;
            start            <= start_n;
            clksel           <= clksel_n;
            bit_cnt          <= bit_cnt_n;
            div              <= div_n;
            first            <= first_n;
            sclk_out         <= sclk_n;
            serial_out       <= sout_n;
            serial_interrupt <= irq_n;
            sync             <= sync_n;
        end
    end

    always_comb begin
        state_n   = state;
        sb_n      = sb;
        start_n   = start;
        clksel_n  = clksel;
        bit_cnt_n = bit_cnt;
        div_n     = div;
        first_n   = first;
        sclk_n    = sclk_out;
        sout_n    = serial_out;
        irq_n     = 1'b0;
        sync_n    = {sync[0], sclk_in};
        rise      = 1'b0;
        fall      = 1'b0;

        if (sc_wr) begin
            start_n  = data_ext[7];
            clksel_n = data_ext[0];
        end

        unique case (state)
            IDLE: begin
                if (sb_wr)
                    sb_n = data_ext;
            end
            SHIFT: begin
                if (stop) begin
                    state_n = IDLE;
                    sclk_n  = 1'b1;
                end else begin
                    if (clksel) begin
                        if (first) begin
                            first_n = 1'b0;
                            sclk_n  = 1'b0;
                        end else if (div == DW'(H - 1)) begin
                            div_n  = '0;
                            sclk_n = !sclk_out;
                            rise   = !sclk_out;
                            fall   = sclk_out;
                        end else begin
                            div_n = div + 1'b1;
                        end
                    end else begin
                        sclk_n = 1'b1;
                        rise   = ext_rise;
                        fall   = ext_fall;
                    end
                    if (rise) begin
                        sb_n      = {sb[6:0], serial_in};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state_n = DONE;
                    end
                    if (fall)
                        sout_n = sb[7];
                end
            end
            DONE: begin
                irq_n   = 1'b1;
                state_n = IDLE;
                start_n = sc_wr ? data_ext[7] : 1'b0;
            end
            default: state_n = IDLE;
        endcase

        // a start write while idle or completing launches a fresh transfer
        if (go && state != SHIFT) begin
            state_n   = SHIFT;
            div_n     = '0;
            bit_cnt_n = 3'd0;
            first_n   = 1'b1;
            sclk_n    = 1'b1;
            sout_n    = sb[7];
        end
    end

endmodule

// File: tb/tb_serial_link.sv
// Directed bench for serial_link with CLK_DIV=4: register access, internal
// and external transfers, partial reads, abort, reset and back-to-back starts.
module tb_serial_link;

    localparam logic [15:0] SB = 16'hFF01;
    localparam logic [15:0] SC = 16'hFF02;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] addr_ext = 16'h0000;
    logic        mem_re = 1'b0;
    logic        mem_we = 1'b0;
    logic        sclk_in = 1'b1;
    logic        si = 1'b0;
    logic        loop_en = 1'b0;
    logic [7:0]  drv = 8'h00;
    logic        drv_en = 1'b0;
    wire  [7:0]  data_ext;
    wire         serial_in;
    logic        sclk_out, serial_out, serial_interrupt;

    int total = 0;
    int bad = 0;

    assign data_ext  = drv_en ? drv : 8'hzz;
    assign serial_in = loop_en ? serial_out : si;

    always #5 clock = ~clock;

    serial_link #(.CLK_DIV(4)) dut (
        .clock(clock),
        .reset(reset),
        .addr_ext(addr_ext),
        .data_ext(data_ext),
        .mem_re(mem_re),
        .mem_we(mem_we),
        .sclk_in(sclk_in),
        .serial_in(serial_in),
        .sclk_out(sclk_out),
        .serial_out(serial_out),
        .serial_interrupt(serial_interrupt)
    );

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        addr_ext = a;
        drv      = d;
        drv_en   = 1'b1;
        mem_we   = 1'b1;
        @(posedge clock);
        #1;
        mem_we   = 1'b0;
        drv_en   = 1'b0;
        addr_ext = 16'h0000;
        @(negedge clock);
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        addr_ext = a;
        mem_re   = 1'b1;
        #1;
        d        = data_ext;
        mem_re   = 1'b0;
        addr_ext = 16'h0000;
    endtask

    task automatic test_reset;
        logic [7:0] v;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        total++;
        if (sclk_out !== 1'b1) begin
            bad++; $display("FAIL rst_sclk got=%b exp=1", sclk_out);
        end
        total++;
        if (serial_out !== 1'b1) begin
            bad++; $display("FAIL rst_sout got=%b exp=1", serial_out);
        end
        total++;
        if (serial_interrupt !== 1'b0) begin
            bad++; $display("FAIL rst_irq got=%b exp=0", serial_interrupt);
        end
        bus_read(SC, v);
        total++;
        if (v !== 8'h7E) begin
            bad++; $display("FAIL rst_sc got=%h exp=7e", v);
        end
        bus_read(SB, v);
        total++;
        if (v !== 8'h00) begin
            bad++; $display("FAIL rst_sb got=%h exp=00", v);
        end
        drv = 8'h5A; drv_en = 1'b1;
        #1;
        total++;
        if (data_ext !== 8'h5A) begin
            bad++; $display("FAIL bus_idle got=%h exp=5a", data_ext);
        end
        drv = 8'hC3; addr_ext = 16'hFF03; mem_re = 1'b1;
        #1;
        total++;
        if (data_ext !== 8'hC3) begin
            bad++; $display("FAIL bus_other got=%h exp=c3", data_ext);
        end
        mem_re = 1'b0; drv_en = 1'b0; addr_ext = 16'h0000;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_loopback;
        logic [7:0] v, got;
        int nb, irq_at, irq_cnt;
        logic prev, s1;
        loop_en = 1'b1;
        bus_write(SB, 8'hA5);
        bus_write(SC, 8'h81);
        nb = 0; irq_at = -1; irq_cnt = 0; prev = sclk_out; got = 8'h00; s1 = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clock);
            if (cyc == 1) s1 = sclk_out;
            if (!sclk_out && prev && nb < 8) begin
                got = {got[6:0], serial_out};
                nb++;
            end
            prev = sclk_out;
            if (serial_interrupt) begin
                irq_cnt++;
                irq_at = cyc;
            end
        end
        total++;
        if (s1 !== 1'b0) begin
            bad++; $display("FAIL lb_first_fall got=%b exp=0", s1);
        end
        total++;
        if (nb != 8 || got !== 8'hA5) begin
            bad++; $display("FAIL lb_bits got=%h/%0d exp=a5/8", got, nb);
        end
        total++;
        if (irq_cnt != 1 || irq_at != 32) begin
            bad++; $display("FAIL lb_irq got=%0d@%0d exp=1@32", irq_cnt, irq_at);
        end
        bus_read(SB, v);
        total++;
        if (v !== 8'hA5) begin
            bad++; $display("FAIL lb_sb got=%h exp=a5", v);
        end
        bus_read(SC, v);
        total++;
        if (v !== 8'h7F) begin
            bad++; $display("FAIL lb_sc got=%h exp=7f", v);
        end
        loop_en = 1'b0;
    endtask

    task automatic test_partial;
        logic [7:0] v, mid;
        int irq_cnt;
        si = 1'b1;
        bus_write(SB, 8'h3C);
        bus_write(SC, 8'h81);
        irq_cnt = 0; mid = 8'h00;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clock);
            if (cyc == 15) bus_read(SB, mid);
            if (serial_interrupt) irq_cnt++;
        end
        total++;
        if (mid !== 8'hCF) begin
            bad++; $display("FAIL part_mid got=%h exp=cf", mid);
        end
        bus_read(SB, v);
        total++;
        if (v !== 8'hFF) begin
            bad++; $display("FAIL part_end got=%h exp=ff", v);
        end
        total++;
        if (irq_cnt != 1) begin
            bad++; $display("FAIL part_irq got=%0d exp=1", irq_cnt);
        end
        si = 1'b0;
    endtask

    task automatic test_external;
        logic [7:0] v;
        int irq_cnt, irq_p, irq_k, low_cnt;
        si = 1'b0;
        bus_write(SB, 8'hFF);
        bus_write(SC, 8'h80);
        irq_cnt = 0; irq_p = -1; irq_k = -1; low_cnt = 0;
        for (int p = 0; p < 8; p++) begin
            sclk_in = 1'b0;
            for (int k = 1; k <= 5; k++) begin
                @(negedge clock);
                if (!sclk_out) low_cnt++;
                if (serial_interrupt) irq_cnt++;
            end
            sclk_in = 1'b1;
            for (int k = 1; k <= 5; k++) begin
                @(negedge clock);
                if (!sclk_out) low_cnt++;
                if (serial_interrupt) begin
                    irq_cnt++; irq_p = p; irq_k = k;
                end
            end
        end
        total++;
        if (irq_cnt != 1 || irq_p != 7 || irq_k < 2 || irq_k > 3) begin
            bad++;
            $display("FAIL ext_irq got=%0d p%0d k%0d exp=1 p7 k2..3", irq_cnt, irq_p, irq_k);
        end
        total++;
        if (low_cnt != 0) begin
            bad++; $display("FAIL ext_sclk_out got=%0d low exp=0", low_cnt);
        end
        bus_read(SB, v);
        total++;
        if (v !== 8'h00) begin
            bad++; $display("FAIL ext_sb got=%h exp=00", v);
        end
        bus_read(SC, v);
        total++;
        if (v !== 8'h7E) begin
            bad++; $display("FAIL ext_sc got=%h exp=7e", v);
        end
    endtask

    task automatic test_abort;
        logic [7:0] v;
        int irq_cnt, low_cnt;
        si = 1'b0;
        bus_write(SB, 8'hF0);
        bus_write(SC, 8'h81);
        repeat (11) @(negedge clock);
        bus_write(SB, 8'h55);
        bus_write(SC, 8'h01);
        total++;
        if (sclk_out !== 1'b1) begin
            bad++; $display("FAIL abort_sclk got=%b exp=1", sclk_out);
        end
        bus_read(SB, v);
        total++;
        if (v !== 8'h80) begin
            bad++; $display("FAIL abort_sb got=%h exp=80", v);
        end
        bus_read(SC, v);
        total++;
        if (v !== 8'h7F) begin
            bad++; $display("FAIL abort_sc got=%h exp=7f", v);
        end
        irq_cnt = 0; low_cnt = 0;
        repeat (40) begin
            @(negedge clock);
            if (serial_interrupt) irq_cnt++;
            if (!sclk_out) low_cnt++;
        end
        total++;
        if (irq_cnt != 0 || low_cnt != 0) begin
            bad++; $display("FAIL abort_idle got=irq%0d low%0d exp=0/0", irq_cnt, low_cnt);
        end
        bus_write(SB, 8'h55);
        bus_read(SB, v);
        total++;
        if (v !== 8'h55) begin
            bad++; $display("FAIL abort_sb_wr got=%h exp=55", v);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] v;
        int irq_cnt, low_cnt;
        si = 1'b0;
        bus_write(SB, 8'hA5);
        bus_write(SC, 8'h81);
        repeat (19) @(negedge clock);
        bus_read(SB, v);
        total++;
        if (v !== 8'hA0) begin
            bad++; $display("FAIL mid_sb got=%h exp=a0", v);
        end
        reset = 1'b0;
        #1;
        total++;
        if ({sclk_out, serial_out, serial_interrupt} !== 3'b110) begin
            bad++;
            $display("FAIL mid_rst_out got=%b exp=110", {sclk_out, serial_out, serial_interrupt});
        end
        bus_read(SB, v);
        total++;
        if (v !== 8'h00) begin
            bad++; $display("FAIL mid_rst_sb got=%h exp=00", v);
        end
        bus_read(SC, v);
        total++;
        if (v !== 8'h7E) begin
            bad++; $display("FAIL mid_rst_sc got=%h exp=7e", v);
        end
        @(negedge clock);
        reset = 1'b1;
        irq_cnt = 0; low_cnt = 0;
        repeat (40) begin
            @(negedge clock);
            if (serial_interrupt) irq_cnt++;
            if (!sclk_out) low_cnt++;
        end
        total++;
        if (irq_cnt != 0 || low_cnt != 0) begin
            bad++; $display("FAIL mid_after got=irq%0d low%0d exp=0/0", irq_cnt, low_cnt);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] v;
        int irq_cnt, irq_at;
        loop_en = 1'b1;
        bus_write(SB, 8'hA5);
        bus_write(SC, 8'h81);
        irq_cnt = 0;
        for (int cyc = 1; cyc <= 31; cyc++) begin
            @(negedge clock);
            if (serial_interrupt) irq_cnt++;
        end
        bus_write(SC, 8'h81);
        total++;
        if (serial_interrupt !== 1'b1 || irq_cnt != 0) begin
            bad++;
            $display("FAIL b2b_irq1 got=%b early%0d exp=1 early0", serial_interrupt, irq_cnt);
        end
        bus_read(SC, v);
        total++;
        if (v !== 8'hFF) begin
            bad++; $display("FAIL b2b_sc got=%h exp=ff", v);
        end
        @(negedge clock);
        total++;
        if (sclk_out !== 1'b0) begin
            bad++; $display("FAIL b2b_restart got=%b exp=0", sclk_out);
        end
        irq_cnt = 0; irq_at = -1;
        for (int cyc = 2; cyc <= 36; cyc++) begin
            @(negedge clock);
            if (serial_interrupt) begin
                irq_cnt++; irq_at = cyc;
            end
        end
        total++;
        if (irq_cnt != 1 || irq_at != 32) begin
            bad++; $display("FAIL b2b_irq2 got=%0d@%0d exp=1@32", irq_cnt, irq_at);
        end
        bus_read(SB, v);
        total++;
        if (v !== 8'hA5) begin
            bad++; $display("FAIL b2b_sb got=%h exp=a5", v);
        end
        loop_en = 1'b0;
    endtask

    initial begin
        test_reset;
        test_loopback;
        test_partial;
        test_external;
        test_abort;
        test_reset_mid;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
